// File: rtl/logic_pkg.sv
// Shared definitions for the sequential logic unit: op codes, FSM encoding, helper widths.
package logic_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_AND   = 3'd0;
  localparam logic [OPW-1:0] OP_OR    = 3'd1;
  localparam logic [OPW-1:0] OP_XOR   = 3'd2;
  localparam logic [OPW-1:0] OP_NOR   = 3'd3;
  localparam logic [OPW-1:0] OP_NAND  = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR  = 3'd5;
  localparam logic [OPW-1:0] OP_PASS_A = 3'd6;
  localparam logic [OPW-1:0] OP_NOT_A = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Slice counter needs at least one bit even when the whole word fits in one slice.
  function automatic int unsigned cnt_width(input int unsigned nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Operand/result handshake bundle for logic_unit_seq.
interface logic_unit_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  import logic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/logic_slice.sv
// Combinational bitwise op on one SLICE-wide chunk of the operands.
module logic_slice
  import logic_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NOR:    y = ~(a | b);
      OP_NAND:   y = ~(a & b);
      OP_XNOR:   y = ~(a ^ b);
      OP_PASS_A: y = a;
      OP_NOT_A:  y = ~a;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: captures a/b/op, produces SLICE result bits per clock,
// then holds result/zero until the consumer accepts them.
module logic_unit_seq
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic            clk,
  input logic            rst_n,
  logic_unit_seq_if.slave bus
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned CW  = cnt_width(NSL);

  if (WIDTH % SLICE != 0) begin : g_param_check
    $fatal(1, "logic_unit_seq: SLICE must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             zero_acc_q, zero_acc_d;
  logic             zero_q, zero_d;
  logic [SLICE-1:0] a_s, b_s, y_s;
  logic             last_slice;

  assign a_s        = a_q[32'(cnt_q) * SLICE +: SLICE];
  assign b_s        = b_q[32'(cnt_q) * SLICE +: SLICE];
  assign last_slice = (cnt_q == CW'(NSL - 1));

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_s),
    .b  (b_s),
    .op (op_q),
    .y  (y_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    zero_acc_d = zero_acc_q;
    zero_d     = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d        = bus.a;
          b_d        = bus.b;
          op_d       = bus.op;
          cnt_d      = '0;
          zero_acc_d = 1'b1;
          zero_d     = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        res_d[32'(cnt_q) * SLICE +: SLICE] = y_s;
        zero_acc_d = zero_acc_q & (y_s == '0);
        if (last_slice) begin
          zero_d  = zero_acc_q & (y_s == '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      zero_acc_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      zero_acc_q <= zero_acc_d;
      zero_q     <= zero_d;
    end
  end

  // in_ready is gated by rst_n so it stays low for the whole reset pulse.
  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: directed cases, backpressure, reset abort,
// slice-width variants and a randomized run against a behavioural model.
module tb_logic_unit_seq;
  import logic_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SLICE = 8;
  localparam int unsigned NSL   = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_seq_if #(.WIDTH(WIDTH)) bus ();
  logic_unit_seq_if #(.WIDTH(WIDTH)) if_w ();
  logic_unit_seq_if #(.WIDTH(WIDTH)) if_n ();

  logic_unit_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic_unit_seq #(.WIDTH(WIDTH), .SLICE(WIDTH)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w)
  );

  logic_unit_seq #(.WIDTH(WIDTH), .SLICE(1)) u_dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_n)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main DUT; out_ready held low for `hold` cycles in DONE while the
  // source scribbles on its inputs, which must not be captured.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                        input logic [WIDTH-1:0] exp, input int hold, input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, bus.in_ready, 1);
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, NSL);
    check({tag, " result"}, bus.result, exp);
    check({tag, " zero"}, bus.zero, (exp == '0));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = $urandom;
      bus.b = $urandom;
      bus.op = 3'($urandom_range(0, 7));
      tick();
      check({tag, " hold out_valid"}, bus.out_valid, 1);
      check({tag, " hold result"}, bus.result, exp);
      check({tag, " hold zero"}, bus.zero, (exp == '0));
      check({tag, " hold in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " drain out_valid"}, bus.out_valid, 0);
    check({tag, " drain in_ready"}, bus.in_ready, 1);
    tick();
    check({tag, " idle in_ready"}, bus.in_ready, 1);
    check({tag, " idle out_valid"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [2:0]       rop;
    logic [WIDTH-1:0] sweep_exp [8];
    int n;

    sweep_exp = '{32'hAAAA0000, 32'hFFFF5555, 32'h55555555, 32'h0000AAAA,
                  32'h5555FFFF, 32'hAAAAAAAA, 32'hAAAA5555, 32'h5555AAAA};
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.op = '0;  bus.out_ready = 1'b0;
    if_w.in_valid = 1'b0; if_w.a = '0; if_w.b = '0; if_w.op = '0; if_w.out_ready = 1'b0;
    if_n.in_valid = 1'b0; if_n.a = '0; if_n.b = '0; if_n.op = '0; if_n.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst result", bus.result, 0);
    check("rst zero", bus.zero, 0);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", bus.in_ready, 1);
    tick();

    // Reset mid-RUN aborts the op
    bus.a = 32'hFFFFFFFF; bus.op = OP_PASS_A; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("midrun partial", (bus.result != '0), 1);
    rst_n = 1'b0;
    #1;
    check("midrun rst out_valid", bus.out_valid, 0);
    check("midrun rst result", bus.result, 0);
    check("midrun rst zero", bus.zero, 0);
    check("midrun rst in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("midrun release in_ready", bus.in_ready, 1);

    // Reset mid-DONE drops the pending result
    bus.a = '0; bus.op = OP_PASS_A; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (NSL + 1) tick();
    check("middone out_valid", bus.out_valid, 1);
    check("middone zero", bus.zero, 1);
    rst_n = 1'b0;
    #1;
    check("middone rst out_valid", bus.out_valid, 0);
    check("middone rst zero", bus.zero, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_op(32'hFFFF0000, 32'h0F0F0F0F, OP_XOR, 32'hF0F00F0F, 0, "xor");
    run_op(32'hDEADBEEF, 32'hDEADBEEF, OP_XOR, 32'h0, 0, "xor_zero");
    run_op(32'h0, 32'h12345678, OP_PASS_A, 32'h0, 0, "pass_zero");
    for (int i = 0; i < 8; i++) begin
      run_op(32'hAAAA5555, 32'hFFFF0000, 3'(i), sweep_exp[i], 0, $sformatf("sweep%0d", i));
      check($sformatf("sweep%0d model", i), model(32'hAAAA5555, 32'hFFFF0000, 3'(i)),
            bus.result);
    end
    run_op(32'h13579BDF, 32'h2468ACE0, OP_NAND, ~(32'h13579BDF & 32'h2468ACE0), 10, "backpressure");

    // SLICE == WIDTH: single-cycle latency
    if_w.a = 32'hCAFEF00D; if_w.b = 32'h0F0F0F0F; if_w.op = OP_AND; if_w.in_valid = 1'b1;
    tick();
    if_w.in_valid = 1'b0;
    n = 0;
    while (!if_w.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("wide latency", n, 1);
    check("wide result", if_w.result, 32'h0A0E000D);
    if_w.out_ready = 1'b1;
    tick();
    if_w.out_ready = 1'b0;
    check("wide drain", if_w.out_valid, 0);

    // SLICE == 1: one bit per cycle
    if_n.a = 32'h80000001; if_n.b = 32'h80000001; if_n.op = OP_XNOR; if_n.in_valid = 1'b1;
    tick();
    if_n.in_valid = 1'b0;
    n = 0;
    while (!if_n.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("narrow latency", n, 32);
    check("narrow result", if_n.result, 32'hFFFFFFFF);
    check("narrow zero", if_n.zero, 0);
    if_n.out_ready = 1'b1;
    tick();
    if_n.out_ready = 1'b0;

    // Randomized operands, ops and backpressure
    for (int i = 0; i < 1000; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(ra, rb, rop, model(ra, rb, rop), int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
